// File: rtl/grid_arbiter.sv
// grid_arbiter
// Arbitrates a single-port grid RAM between a VGA reader and a game
// reader/writer, and runs a full-grid clear sweep for each new round.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   vga_req, vga_x, vga_y        VGA read request and cell coordinate
//   vga_gnt, vga_rvalid, vga_rdata
//                                VGA grant, read-valid (cycle after grant), data
//   game_req, game_we, game_x, game_y, game_wdata
//                                game request, write enable, coordinate, data
//   game_gnt, game_rvalid, game_rdata
//                                game grant, read-valid, read data
//   clear_start                  begin a grid re-initialisation sweep
//   clear_busy, clear_done       sweep in progress, one-cycle completion pulse
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata
//                                single-port RAM, address {y,x}, 1-cycle read
module grid_arbiter #(
  parameter int GRID_SIZE     = 32,
  parameter int LOG_GRID_SIZE = 5,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vga_req,
  input  logic [LOG_GRID_SIZE-1:0]   vga_x,
  input  logic [LOG_GRID_SIZE-1:0]   vga_y,
  output logic                       vga_gnt,
  output logic                       vga_rvalid,
  output logic                       vga_rdata,
  input  logic                       game_req,
  input  logic                       game_we,
  input  logic [LOG_GRID_SIZE-1:0]   game_x,
  input  logic [LOG_GRID_SIZE-1:0]   game_y,
  input  logic                       game_wdata,
  output logic                       game_gnt,
  output logic                       game_rvalid,
  output logic                       game_rdata,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [2*LOG_GRID_SIZE-1:0] ram_addr,
  output logic                       ram_wdata,
  input  logic                       ram_rdata
);

  localparam int AW   = 2 * LOG_GRID_SIZE;
  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic SERVE = 1'b0;
  localparam logic CLEAR = 1'b1;

  localparam logic [SC_W-1:0]          STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0]          SC_ONE     = SC_W'(1);
  localparam logic [AW-1:0]            CNT_ONE    = AW'(1);
  localparam logic [AW-1:0]            CLR_LAST   = '1;
  localparam logic [LOG_GRID_SIZE-1:0] EDGE_HI    = LOG_GRID_SIZE'(GRID_SIZE - 1);

  logic            state;
  logic [SC_W-1:0] starve_cnt;
  logic [AW-1:0]   clr_cnt;
  logic            starve_hit;
  logic            clr_border;

  assign starve_hit = (starve_cnt == STARVE_MAX);

  // Border cells of the swept address: x is the low half, y the high half.
  assign clr_border = (clr_cnt[LOG_GRID_SIZE-1:0] == '0)
                   || (clr_cnt[LOG_GRID_SIZE-1:0] == EDGE_HI)
                   || (clr_cnt[AW-1:LOG_GRID_SIZE] == '0)
                   || (clr_cnt[AW-1:LOG_GRID_SIZE] == EDGE_HI);

  // Grants are combinational so a requester is served in the cycle it asks.
  // reset_n gates them so nothing reaches the RAM while reset is held.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // a signal unassigned would otherwise infer a latch.
  always_comb begin
    vga_gnt  = 1'b0;
    game_gnt = 1'b0;
    if (reset_n && (state == SERVE) && !clear_start) begin
      game_gnt = game_req && (!vga_req || starve_hit);
      vga_gnt  = vga_req && !game_gnt;
    end
  end

  // RAM port mux: the clear sweep owns the RAM outright, otherwise the winner.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 1'b0;
    if (state == CLEAR) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt;
      ram_wdata = clr_border;
    end else if (game_gnt) begin
      ram_en    = 1'b1;
      ram_we    = game_we;
      ram_addr  = {game_y, game_x};
      ram_wdata = game_wdata;
    end else if (vga_gnt) begin
      ram_en    = 1'b1;
      ram_addr  = {vga_y, vga_x};
      ram_wdata = game_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SERVE;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (state == SERVE) begin
        if (clear_start) state <= CLEAR;
      end else begin
        clr_cnt <= clr_cnt + CNT_ONE;   // wraps to 0 after the last cell
        if (clr_cnt == CLR_LAST) begin
          state      <= SERVE;
          clear_done <= 1'b1;
        end
      end
    end
  end

  // Counts consecutive cycles the game port lost to VGA. Any cycle where the
  // game port is idle, granted, or the sweep takes over restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if ((state == CLEAR) || clear_start || !game_req || game_gnt) begin
      starve_cnt <= '0;
    end else if (vga_gnt) begin
      starve_cnt <= starve_cnt + SC_ONE;
    end
  end

  // Read-valid follows the grant by one cycle to match the RAM latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_rvalid  <= 1'b0;
      game_rvalid <= 1'b0;
    end else begin
      vga_rvalid  <= vga_gnt;
      game_rvalid <= game_gnt && !game_we;
    end
  end

  assign vga_rdata  = reset_n & ram_rdata;
  assign game_rdata = reset_n & ram_rdata;
  assign clear_busy = (state == CLEAR);

endmodule
